tile_result_packer: RTL and testbench
=====================================

# tile_result_packer

Write-side counterpart of the 4x4 tile unpacker in the single-MAC matrix multiplier. It accepts scalar accumulator results from the MAC one at a time and scales each to a WIDTH-bit element. Sixteen elements are packed row-major into one WIDTH*WIDTH-bit tile word, which is then written to result RAM at an auto-incrementing tile address. The bit layout matches the one the unpacker reads, so packed words are directly readable by the unpacker.

## Interface
- WIDTH, 16, element width; tile word is WIDTH*WIDTH bits.
- FACTOR, 2754, number of tiles per matrix; tile address wraps after FACTOR-1.
- ACC_WIDTH, 32, signed accumulator input width.
- FRAC, 8, fraction bits dropped when scaling accumulator to element.
- ADDR_WIDTH, 12, tile address width; must satisfy 2^ADDR_WIDTH >= FACTOR.
- clk  in  1  clock; single clock domain, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- acc_valid  in  1  accumulator result valid.
- acc_data  in  ACC_WIDTH  signed accumulator result.
- acc_ready  out  1  packer can accept an element.
- wr_en  out  1  tile write request, held until accepted.
- wr_addr  out  ADDR_WIDTH  tile address.
- wr_data  out  WIDTH*WIDTH  packed tile word.
- wr_ready  in  1  RAM accepts write this cycle.
- done  out  1  one-cycle pulse when tile FACTOR-1 is written.

## Operation
- FSM states: FILL, WRITE. Reset state is FILL.
- FILL:
  - acc_ready=1.
  - Each handshake (acc_valid&&acc_ready at posedge) stores the scaled element at index k = elem_cnt.
  - Element k occupies wr_data[WIDTH*WIDTH-1-WIDTH*k : WIDTH*WIDTH-WIDTH*(k+1)]. So k=0 is out00 at [255:240] and k=15 is out33 at [15:0].
  - elem_cnt increments by 1 per handshake.
  - On the handshake with elem_cnt==15: elem_cnt->0 and state->WRITE.
- WRITE:
  - acc_ready=0. wr_en=1. wr_data and wr_addr are stable.
  - On wr_ready at posedge: state->FILL.
  - wr_addr increments by 1, wrapping FACTOR-1 -> 0.
  - done=1 in the cycle following the accepting edge, only if the accepted wr_addr was FACTOR-1.
- Scaling (default): element = acc_data[FRAC+WIDTH-1:FRAC], plain truncation with no rounding.
- acc_data is ignored whenever there is no handshake.
- Reset values: acc_ready=1 (FILL), wr_en=0, wr_addr=0, wr_data=0, done=0, elem_cnt=0.
- Reset mid-operation discards the partial tile or the pending write; the next tile goes to address 0.
- wr_data slots not yet written in the current tile hold stale data. This is legal because wr_data is only meaningful while wr_en=1.

## Timing
- acc_ready and wr_en are decoded from the state register only; no combinational path exists from acc_valid or wr_ready.
- 16th element accepted at edge N: wr_en=1 after edge N.
- wr_ready held high: write accepted at edge N+1, and acc_ready=1 after edge N+1.
- Minimum 17 cycles per tile at full throughput.
- wr_ready low stalls WRITE indefinitely. wr_en, wr_addr and wr_data do not change during the stall.
- acc_valid asserted during WRITE is not accepted; the upstream MAC must hold its data.
- done is registered and is never asserted for two consecutive cycles.

## Configuration
- TILE_PACKER_SAT_EN defined:
  - Scaling saturates to the signed WIDTH range. If acc_data>>>FRAC exceeds 2^(WIDTH-1)-1, the element is 0x7FFF for WIDTH=16.
  - If acc_data>>>FRAC is below -2^(WIDTH-1), the element is 0x8000.
  - Otherwise the element is truncated as in the default.
- TILE_PACKER_SAT_EN undefined: plain truncation only, with no compare logic.

## Test plan
- Reset, then 16 back-to-back elements with acc_data = k<<8 (k=0..15), wr_ready=1 -> wr_en rises after the 16th edge with wr_data = 0x0000_0001_0002_..._000F and wr_addr=0. Accepted next edge; acc_ready returns.
- Same stimulus with wr_ready held low 5 cycles -> wr_en and wr_data stable for 5 cycles, acc_ready=0 throughout, and no element lost from the following tile.
- acc_data=0x0001_2345 in slot 0 -> bits [255:240]=0x0123.
- acc_data=0x0100_0000 and 0xFF00_0000 -> with TILE_PACKER_SAT_EN: 0x7FFF and 0x8000. Without it: 0x0000 and 0x0000.
- FACTOR=3, write 4 tiles -> addresses 0,1,2,0. done pulses exactly once, the cycle after the address-2 write.
- Assert rst_n low after 7 elements -> outputs return to reset values. The next 16 elements produce a tile at wr_addr=0 containing only the new data.

Source files
------------

// File: rtl/tile_result_packer.sv
// ============================================================================
// tile_result_packer: scales MAC accumulator results and packs sixteen of them
// row-major into one tile word for result RAM. Optional: TILE_PACKER_SAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_result_packer #(
   parameter int WIDTH      = 16,
   parameter int FACTOR     = 2754,
   parameter int ACC_WIDTH  = 32,
   parameter int FRAC       = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   acc_valid,
   input  logic [ACC_WIDTH-1:0]   acc_data,
   output logic                   acc_ready,
   output logic                   wr_en,
   output logic [ADDR_WIDTH-1:0]  wr_addr,
   output logic [WIDTH*WIDTH-1:0] wr_data,
   input  logic                   wr_ready,
   output logic                   done
);

   localparam int                    c_TILE_W    = WIDTH * WIDTH;
   localparam int                    c_ELEMS     = 16;
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FACTOR - 1);

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_elem_cnt;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic                  r_done;
   logic [WIDTH-1:0]      r_slot [c_ELEMS];
   logic [WIDTH-1:0]      w_elem;
   logic                  w_acc_hs;
   logic                  w_wr_acc;
   logic                  w_unused;

   assign w_acc_hs = acc_valid && (r_state == FILL);
   assign w_wr_acc = wr_ready  && (r_state == WRITE);
   assign w_unused = ^{acc_data[FRAC-1:0], acc_data[ACC_WIDTH-1:FRAC+WIDTH]};

`ifdef TILE_PACKER_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] c_EL_MAX = ACC_WIDTH'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] c_EL_MIN = -(ACC_WIDTH'(2 ** (WIDTH - 1)));

   logic signed [ACC_WIDTH-1:0] w_shifted;
   assign w_shifted = $signed(acc_data) >>> FRAC;

   always_comb begin
      w_elem = acc_data[FRAC+WIDTH-1:FRAC];
      if (w_shifted > c_EL_MAX) begin
         w_elem = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (w_shifted < c_EL_MIN) begin
         w_elem = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end
`else
   always_comb begin
      w_elem = acc_data[FRAC+WIDTH-1:FRAC];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs depend on the state register only.
   always_comb begin
      w_state_nxt = r_state;
      acc_ready   = 1'b0;
      wr_en       = 1'b0;
      case (r_state)
         FILL: begin
            acc_ready = 1'b1;
            if (w_acc_hs && (r_elem_cnt == 4'd15)) begin
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            wr_en = 1'b1;
            if (wr_ready) begin
               w_state_nxt = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_elem_cnt <= 4'd0;
         for (int k = 0; k < c_ELEMS; k++) begin
            r_slot[k] <= '0;
         end
      end else if (w_acc_hs) begin
         r_elem_cnt         <= r_elem_cnt + 4'd1;
         r_slot[r_elem_cnt] <= w_elem;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_addr <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_wr_acc && (r_wr_addr == c_LAST_ADDR);
         if (w_wr_acc) begin
            r_wr_addr <= (r_wr_addr == c_LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
         end
      end
   end

   // Element 0 sits in the most significant slot so the unpacker reads row-major.
   always_comb begin
      wr_data = '0;
      for (int k = 0; k < c_ELEMS; k++) begin
         wr_data[c_TILE_W-1-WIDTH*k -: WIDTH] = r_slot[k];
      end
   end

   assign wr_addr = r_wr_addr;
   assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tile_result_packer.sv
// ============================================================================
// tb_tile_result_packer: directed stimulus against a queue-based tile model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tile_result_packer;

   localparam int WIDTH      = 16;
   localparam int FACTOR     = 3;
   localparam int ACC_WIDTH  = 32;
   localparam int FRAC       = 8;
   localparam int ADDR_WIDTH = 12;

   logic                   clk;
   logic                   rst_n;
   logic                   acc_valid;
   logic [ACC_WIDTH-1:0]   acc_data;
   logic                   acc_ready;
   logic                   wr_en;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [WIDTH*WIDTH-1:0] wr_data;
   logic                   wr_ready;
   logic                   done;

   tile_result_packer #(
      .WIDTH      (WIDTH),
      .FACTOR     (FACTOR),
      .ACC_WIDTH  (ACC_WIDTH),
      .FRAC       (FRAC),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_valid (acc_valid),
      .acc_data  (acc_data),
      .acc_ready (acc_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int n_done   = 0;
   int alog[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Element value straight from the arithmetic meaning of the scaling rule.
   function automatic logic [15:0] scale(input logic [31:0] a);
      int v;
      v = $signed(a) >>> 8;
`ifdef TILE_PACKER_SAT_EN
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
`endif
      return 16'(v);
   endfunction

   bit             m_pend = 1'b0;
   logic [15:0]    m_q[$];
   logic [255:0]   m_tile = '0;
   int             m_addr = 0;
   bit             m_done = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_pend = 1'b0;
         m_q.delete();
         m_addr = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_pend) begin
            if (wr_ready) begin
               m_done = (m_addr == FACTOR - 1);
               m_addr = (m_addr + 1) % FACTOR;
               m_pend = 1'b0;
            end
         end else if (acc_valid) begin
            m_q.push_back(scale(acc_data));
            if (m_q.size() == 16) begin
               m_tile = '0;
               foreach (m_q[i]) m_tile = (m_tile << 16) | 256'(m_q[i]);
               m_q.delete();
               m_pend = 1'b1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("acc_ready", 256'(acc_ready), 256'(!m_pend));
      chk("wr_en",     256'(wr_en),     256'(m_pend));
      chk("done",      256'(done),      256'(m_done));
      if (m_pend) begin
         chk("wr_addr", 256'(wr_addr), 256'(m_addr));
         chk("wr_data", wr_data,       m_tile);
      end
      if (wr_en && wr_ready) alog.push_back(int'(wr_addr));
      if (done) n_done++;
   end

   task automatic send(input logic [31:0] d, output int waited);
      bit hs;
      waited    = 0;
      acc_valid = 1'b1;
      acc_data  = d;
      do begin
         hs = acc_ready;
         @(posedge clk); #1;
         waited++;
      end while (!hs && waited < 200);
      if (!hs) begin
         n_checks++;
         n_err++;
         $display("FAIL send_timeout: got no handshake expected handshake within 200 cycles");
      end
      acc_valid = 1'b0;
      acc_data  = $urandom;
   endtask

   task automatic wait_write_done();
      int t = 0;
      while (wr_en && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (wr_en) begin
         n_checks++;
         n_err++;
         $display("FAIL write_timeout: got wr_en=1 expected 0 within 100 cycles");
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_acc_ready", 256'(acc_ready), 256'(1));
      chk("rst_wr_en",     256'(wr_en),     256'(0));
      chk("rst_wr_addr",   256'(wr_addr),   256'(0));
      chk("rst_wr_data",   wr_data,         256'(0));
      chk("rst_done",      256'(done),      256'(0));
   endtask

   initial begin
      int w;
      logic [15:0] exp_hi;
      logic [15:0] exp_lo;
      int exp_a[5] = '{0, 1, 2, 0, 0};

      rst_n     = 1'b1;
      acc_valid = 1'b0;
      acc_data  = '0;
      wr_ready  = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;

      // Tile 1: ramp, full throughput.
      for (int k = 0; k < 16; k++) send(32'(k) << 8, w);
      chk("t1_wr_en",   256'(wr_en),   256'(1));
      chk("t1_wr_addr", 256'(wr_addr), 256'(0));
      chk("t1_wr_data", wr_data,
          256'h0000000100020003000400050006000700080009000A000B000C000D000E000F);
      @(posedge clk); #1;
      chk("t1_acc_ready_back", 256'(acc_ready), 256'(1));

      // Tile 2: write stalled for 5 cycles while tile 3 data waits upstream.
      wr_ready = 1'b0;
      for (int k = 0; k < 16; k++) send((32'(k) * 32'd37 + 32'd100) << 8, w);
      fork
         begin
            repeat (5) @(posedge clk);
            #1 wr_ready = 1'b1;
         end
      join_none

      // Tile 3: scaling corner cases in the first three slots.
      send(32'h0001_2345, w);
      chk("stall_wait_cycles", 256'(w), 256'(7));
      send(32'h0100_0000, w);
      send(32'hFF00_0000, w);
      for (int k = 3; k < 16; k++) send($urandom, w);
`ifdef TILE_PACKER_SAT_EN
      exp_hi = 16'h7FFF;
      exp_lo = 16'h8000;
`else
      exp_hi = 16'h0000;
      exp_lo = 16'h0000;
`endif
      chk("t3_slot0", 256'(wr_data[255:240]), 256'(16'h0123));
      chk("t3_slot1", 256'(wr_data[239:224]), 256'(exp_hi));
      chk("t3_slot2", 256'(wr_data[223:208]), 256'(exp_lo));
      chk("t3_wr_addr", 256'(wr_addr), 256'(2));
      wait_write_done();
      @(posedge clk); #1;
      chk("done_once", 256'(n_done), 256'(1));

      // Tile 4: address wraps to 0.
      for (int k = 0; k < 16; k++) send($urandom, w);
      chk("t4_wr_addr", 256'(wr_addr), 256'(0));
      wait_write_done();

      // Partial tile discarded by reset after 7 elements.
      for (int k = 0; k < 7; k++) send(32'hABCD_0000 | 32'(k), w);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs();
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) send((32'(k) + 32'h40) << 8, w);
      chk("t5_wr_addr", 256'(wr_addr), 256'(0));
      chk("t5_first",   256'(wr_data[255:240]), 256'(16'h0040));
      chk("t5_last",    256'(wr_data[15:0]),    256'(16'h004F));
      wait_write_done();
      repeat (3) @(posedge clk);
      #1;

      chk("addr_log_len", 256'(alog.size()), 256'(5));
      if (alog.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("addr_log", 256'(alog[i]), 256'(exp_a[i]));
      end
      chk("done_total", 256'(n_done), 256'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
